// File: rtl/jpeg_zigzag_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_zigzag_pingpong_buf
//  Description : Double-buffered de-zigzag coefficient buffer. Coefficients
//                arrive tagged with their zigzag scan index and are stored in
//                one of two 8x8 banks; committed banks are streamed to the
//                IDCT in natural order over a valid/ready handshake while the
//                writer fills the other bank.
//  Ports       : clk, rst (async, active-low)
//                DataInEnable/DataInAddress/DataIn/DataInLast/DataInReady
//                    - zigzag-indexed write side, DataInLast commits the bank
//                DataOutValid/DataOutReady/DataOut/DataOutIndex/DataOutLast
//                    - natural-order read stream, Last on 64th coefficient
//  Options     : JPEG_ZZBUF_TRANSPOSE_EN - column-major readout order
//                (DataOutIndex still reports row*8+col).
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_zigzag_pingpong_buf #(
    parameter int DATA_W = 16
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              DataInEnable,
    input  logic [5:0]        DataInAddress,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DataInLast,
    output logic              DataInReady,
    output logic              DataOutValid,
    input  logic              DataOutReady,
    output logic [DATA_W-1:0] DataOut,
    output logic [5:0]        DataOutIndex,
    output logic              DataOutLast
);

    // Natural (row*8+col) position -> zigzag scan index.
    localparam logic [5:0] c_nat2zz [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    logic [DATA_W-1:0] r_bank [2][64];   // stored in zigzag order
    logic [1:0]        r_full;
    logic              r_wb;
    logic              r_rb;
    logic [5:0]        r_cnt;

    logic              w_wr_acc;
    logic              w_commit;
    logic              w_rd_acc;
    logic              w_rd_done;
    logic [5:0]        w_nat;

    assign w_wr_acc  = DataInEnable & ~r_full[r_wb];
    assign w_commit  = w_wr_acc & DataInLast;
    assign w_rd_acc  = r_full[r_rb] & DataOutReady;
    assign w_rd_done = w_rd_acc & (r_cnt == 6'd63);

`ifdef JPEG_ZZBUF_TRANSPOSE_EN
    // Column-first walk: cnt low bits select the row, high bits the column.
    assign w_nat = {r_cnt[2:0], r_cnt[5:3]};
`else
    assign w_nat = r_cnt;
`endif

    // Coefficient storage. Index 0 opens a block and wipes the rest of the
    // bank so that indices the entropy decoder skips read back as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 64; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
        end else if (w_wr_acc) begin
            if (DataInAddress == 6'd0) begin
                for (int i = 1; i < 64; i++) begin
                    r_bank[r_wb][i] <= '0;
                end
            end
            r_bank[r_wb][DataInAddress] <= DataIn;
        end
    end

    // Bank ownership. A commit only happens on a free bank and a drain only
    // completes on a full one, so the two can never target the same flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 2'b00;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_cnt  <= 6'd0;
        end else begin
            if (w_commit) begin
                r_full[r_wb] <= 1'b1;
                r_wb         <= ~r_wb;
            end
            if (w_rd_acc) begin
                r_cnt <= r_cnt + 6'd1;   // wraps 63 -> 0
                if (w_rd_done) begin
                    r_full[r_rb] <= 1'b0;
                    r_rb         <= ~r_rb;
                end
            end
        end
    end

    assign DataInReady  = ~r_full[r_wb];
    assign DataOutValid = r_full[r_rb];
    assign DataOut      = r_bank[r_rb][c_nat2zz[w_nat]];
    assign DataOutIndex = w_nat;
    assign DataOutLast  = (r_cnt == 6'd63);

endmodule
`default_nettype wire

// File: tb/tb_jpeg_zigzag_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_zigzag_pingpong_buf
//  Description : Scoreboard bench for jpeg_zigzag_pingpong_buf. Writes are
//                applied to an 8x8 natural-order image model; each commit
//                pushes the 64 expected outputs into a queue that a monitor
//                drains as the DUT transfers coefficients.
//  Options     : JPEG_ZZBUF_TRANSPOSE_EN - expect column-major readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_zigzag_pingpong_buf;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              DataInEnable;
    logic [5:0]        DataInAddress;
    logic [DATA_W-1:0] DataIn;
    logic              DataInLast;
    logic              DataInReady;
    logic              DataOutValid;
    logic              DataOutReady;
    logic [DATA_W-1:0] DataOut;
    logic [5:0]        DataOutIndex;
    logic              DataOutLast;

    jpeg_zigzag_pingpong_buf #(.DATA_W(DATA_W)) dut (
        .rst          (rst),
        .clk          (clk),
        .DataInEnable (DataInEnable),
        .DataInAddress(DataInAddress),
        .DataIn       (DataIn),
        .DataInLast   (DataInLast),
        .DataInReady  (DataInReady),
        .DataOutValid (DataOutValid),
        .DataOutReady (DataOutReady),
        .DataOut      (DataOut),
        .DataOutIndex (DataOutIndex),
        .DataOutLast  (DataOutLast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] v;
        logic [5:0]        n;
        logic              last;
    } exp_t;

    exp_t              q[$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                out_count = 0;
    int                zz_nat[64];      // zigzag index -> natural position
    logic [DATA_W-1:0] img[64];         // current block, natural order
    int                rdy_mode = 0;    // 0 high, 1 toggle, 2 random, 3 low

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Zigzag scan: walk anti-diagonals s=row+col, alternating direction.
    function automatic void build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz_nat[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz_nat[k] = r * 8 + (s - r); k++; end
            end
        end
    endfunction

    task automatic push_block();
        exp_t e;
        for (int t = 0; t < 64; t++) begin
            int n;
`ifdef JPEG_ZZBUF_TRANSPOSE_EN
            n = (t % 8) * 8 + t / 8;
`else
            n = t;
`endif
            e.v    = img[n];
            e.n    = n[5:0];
            e.last = (t == 63);
            q.push_back(e);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic wr(input int a, input logic [DATA_W-1:0] d, input bit last);
        int g = 0;
        DataInEnable  = 1'b1;
        DataInAddress = a[5:0];
        DataIn        = d;
        DataInLast    = last;
        @(negedge clk);
        while (!DataInReady && g < 1000) begin g++; @(negedge clk); end
        if (!DataInReady) begin
            chk("write_timeout", 32'(DataInReady), 32'd1);
            DataInEnable = 1'b0;
            DataInLast   = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        if (a == 0) for (int i = 0; i < 64; i++) img[i] = '0;
        img[zz_nat[a]] = d;
        if (last) push_block();
        DataInEnable = 1'b0;
        DataInLast   = 1'b0;
    endtask

    task automatic rand_block(input int extra);
        wr(0, 16'($urandom), extra == 0);
        for (int i = 0; i < extra; i++)
            wr($urandom_range(0, 63), 16'($urandom), i == extra - 1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (q.size() != 0 && g < 3000) begin @(posedge clk); g++; end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Output-ready driver.
    initial begin
        bit tog = 1'b0;
        DataOutReady = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       DataOutReady = 1'b1;
                1:       begin tog = ~tog; DataOutReady = tog; end
                2:       DataOutReady = ($urandom_range(0, 3) != 0);
                default: DataOutReady = 1'b0;
            endcase
        end
    end

    // Monitor: valid/ready track the model's pending blocks; each presented
    // coefficient (stalled or not) must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(DataOutValid), 32'(q.size() != 0));
            chk("in_ready", 32'(DataInReady), 32'(((q.size() + 63) / 64) < 2));
            if (DataOutValid && q.size() != 0) begin
                e = q[0];
                chk("data", 32'(DataOut), 32'(e.v));
                chk("index", 32'(DataOutIndex), 32'(e.n));
                chk("last", 32'(DataOutLast), 32'(e.last));
                if (DataOutReady) begin
                    void'(q.pop_front());
                    out_count++;
                end
            end
        end
    end

    initial begin
        int base;
        int g;
        build_zz();
        for (int i = 0; i < 64; i++) img[i] = '0;
        rst           = 1'b0;
        DataInEnable  = 1'b0;
        DataInAddress = '0;
        DataIn        = '0;
        DataInLast    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(DataInReady), 32'd1);
        chk("rst_out_valid", 32'(DataOutValid), 32'd0);
        chk("rst_data", 32'(DataOut), 32'd0);
        chk("rst_index", 32'(DataOutIndex), 32'd0);
        chk("rst_last", 32'(DataOutLast), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Full zigzag ramp, ready held high.
        rdy_mode = 0;
        for (int k = 0; k < 64; k++) wr(k, 16'(100 + k), k == 63);
        wait_drain();

        // DC-only block, then a two-entry block over the ramp's stale bank.
        wr(0, 16'h07FF, 1'b1);
        wr(0, 16'd5, 1'b0);
        wr(1, 16'd6, 1'b1);
        wait_drain();

        // Back-to-back: write B while A drains.
        for (int k = 0; k < 64; k++) wr(k, 16'($urandom), k == 63);
        for (int k = 0; k < 64; k++) wr(k, 16'($urandom), k == 63);
        wait_drain();

        // Both banks full, consumer stalled: a write (with Last) is dropped.
        rdy_mode = 3;
        rand_block(63);
        rand_block(5);
        @(negedge clk);
        chk("both_full_ready", 32'(DataInReady), 32'd0);
        @(posedge clk); #1;
        DataInEnable  = 1'b1;
        DataInAddress = 6'd5;
        DataIn        = 16'h1234;
        DataInLast    = 1'b1;
        @(posedge clk); #1;
        DataInEnable  = 1'b0;
        DataInLast    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_drain();

        // Backpressure on alternate cycles.
        rdy_mode = 1;
        rand_block(40);
        wait_drain();

        // Randomized blocks and consumer behaviour.
        for (int b = 0; b < 8; b++) begin
            rdy_mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            rand_block($urandom_range(0, 70));
        end
        rdy_mode = 2;
        wait_drain();

        // Ramp (value = natural index) plus a second committed block, then
        // reset during the 10th-11th output.
        rdy_mode = 3;
        for (int k = 0; k < 64; k++) wr(k, 16'(zz_nat[k]), k == 63);
        rand_block(10);
        base = out_count;
        rdy_mode = 0;
        g = 0;
        while (out_count < base + 10 && g < 500) begin @(posedge clk); g++; end
        if (out_count < base + 10) chk("reset_wait_timeout", 32'(out_count), 32'(base + 10));
        #1;
        rst = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", 32'(DataOutValid), 32'd0);
        chk("midrst_in_ready", 32'(DataInReady), 32'd1);
        chk("midrst_data", 32'(DataOut), 32'd0);
        chk("midrst_index", 32'(DataOutIndex), 32'd0);
        chk("midrst_last", 32'(DataOutLast), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) img[i] = '0;
        rand_block(3);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jpeg_zigzag_pingpong_buf.md
# jpeg_zigzag_pingpong_buf

Double-buffered de-zigzag coefficient buffer for the JPEG decoder. It takes coefficients from the Huffman/dequantiser stage, each tagged with its zigzag scan index, into one of two 8x8 banks. It then streams completed blocks in natural (raster) order to the IDCT over a valid/ready handshake. The writer fills one bank while the IDCT drains the other, which removes the stall that the single-bank register array imposes between blocks.

## Interface
- DATA_W, 16, coefficient width in bits.

- rst  in  1  asynchronous, active-low reset.
- clk  in  1  clock; all state updates on the rising edge.
- DataInEnable  in  1  write strobe; ignored while DataInReady=0.
- DataInAddress  in  6  zigzag scan index, 0..63.
- DataIn  in  DATA_W  coefficient value.
- DataInLast  in  1  qualified by DataInEnable; marks the final write of the block and commits the bank.
- DataInReady  out  1  write bank is free.
- DataOutValid  out  1  output coefficient is valid.
- DataOutReady  in  1  consumer accepts the output coefficient.
- DataOut  out  DATA_W  coefficient in natural order.
- DataOutIndex  out  6  natural index (row*8+col) of DataOut.
- DataOutLast  out  1  high on the 64th coefficient of the block.

## Operation
- Storage: 2 banks x 64 x DATA_W registers, addressed by zigzag index; a full[1:0] flag per bank; write-bank pointer wb; read-bank pointer rb; 6-bit read counter cnt.
- Write, accepted when DataInEnable & DataInReady:
  - bank[wb][DataInAddress] <= DataIn.
  - If DataInAddress==0, entries 1..63 of bank[wb] clear to 0 in the same edge. Every block must begin with index 0; skipped indices therefore read as 0.
  - Repeated writes to the same index: the last write wins.
- Commit: an accepted write with DataInLast=1 sets full[wb] and toggles wb. A block consisting of index 0 alone (0 with Last) is legal.
- Read:
  - DataOutValid = full[rb].
  - Natural index n is derived from cnt: row-major, n=cnt.
  - DataOut = bank[rb][zz(n)], where zz is the standard JPEG natural-to-zigzag map (zz(0)=0, zz(1)=1, zz(8)=2, zz(16)=3, zz(2)=5, zz(63)=63).
  - DataOutIndex = n. DataOutLast = (cnt==63).
- Transfer on DataOutValid & DataOutReady: cnt increments. When cnt==63, cnt wraps to 0, full[rb] clears and rb toggles.
- DataInReady = ~full[wb]. Writes while not ready are dropped with no state change; the upstream stage must hold off.
- Simultaneous commit on one bank and drain-complete on the other in the same edge: both take effect, since the flags are independent.

## Timing
- Reset values:
  - All bank entries 0; full=00; wb=rb=0; cnt=0.
  - DataInReady=1, DataOutValid=0, DataOut=0, DataOutIndex=0, DataOutLast=0.
- Reset asserted mid-block discards both banks and any partial stream.
- Commit-to-output latency: 1 cycle. DataOutValid rises the cycle after the committing edge.
- Output path is combinational from registers and cnt: zero-cycle read; DataOut updates in the cycle after each transfer.
- Throughput: 1 coefficient/cycle when DataOutReady is held high; 64 cycles per block.
- With both banks full, DataInReady=0 until the final transfer of the draining block. Ready re-asserts the cycle after that edge.
- DataOut, DataOutIndex and DataOutLast hold stable while DataOutValid=1 and DataOutReady=0.

## Configuration
- JPEG_ZZBUF_TRANSPOSE_EN:
  - Defined: readout is column-major, n = {cnt[2:0], cnt[5:3]}, giving the index sequence 0,8,16,..,56,1,9,.. for a column-first IDCT pass. DataOutIndex still reports the natural row*8+col index.
  - Undefined: row-major, n=cnt.
  - Write side is identical in both builds.

## Test plan
- Reset, then write zigzag 0..63 with DataIn=100+k and Last on 63, ready held high: 64 outputs in order. Index 0 =100, index 8 =102, index 2 =105, index 63 =163; Last only on the 64th; Valid rises 1 cycle after commit.
- DC-only block: a single write of index 0 =0x7FF with Last: outputs 0x7FF, then 63 zeros. Then write idx0=5, idx1=6 with Last: stale values from the previous block's bank are cleared (index 1 =6, all others 0 except index 0 =5).
- Back-to-back: commit block A, start block B while A drains with ready=1: no drop and no stall; B becomes valid the cycle after A's 64th transfer if B is already committed.
- Both banks full with DataOutReady=0: DataInReady=0 and a write of 0x1234 is dropped. After 64 accepted reads, DataInReady returns to 1 the following cycle.
- Backpressure: toggle DataOutReady every other cycle; each of the 64 values is emitted exactly once and held stable while stalled.
- With JPEG_ZZBUF_TRANSPOSE_EN, a ramp block (natural value = n) outputs 0,8,16,...,56,1,9,... with matching DataOutIndex. Asserting rst at output 10 returns all outputs to reset values and discards both banks.
